// File: rtl/seq_pkg.sv
// rtl/seq_pkg.sv - shared state encoding and sizing helper for the serializer
package seq_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  // Bit-counter width for a given word length; callers guarantee w >= 2.
  function automatic int cnt_width(input int w);
    return $clog2(w);
  endfunction

endpackage

// File: rtl/seq_serializer.sv
// rtl/seq_serializer.sv - parallel-to-serial front end for the 101 detector
module seq_serializer
  import seq_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             busy,
  output logic             done
);

  localparam int              CNT_W    = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e           state_q;
  state_e           state_d;
  logic [WIDTH-1:0] shreg_q;
  logic [WIDTH-1:0] shreg_next;
  logic [CNT_W-1:0] cnt_q;
  logic             last_bit;
  logic             accept;

  // Ready is a function of registered state only, so nothing upstream can
  // form a combinational loop through load_valid.
  assign last_bit   = (state_q == ST_SHIFT) && (cnt_q == '0);
  assign load_ready = (state_q == ST_IDLE) || last_bit;
  assign accept     = load_valid && load_ready;

  generate
    if (MSB_FIRST) begin : g_msb
      assign shreg_next = {shreg_q[WIDTH-2:0], 1'b0};
    end else begin : g_lsb
      assign shreg_next = {1'b0, shreg_q[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept) state_d = ST_SHIFT;
      ST_SHIFT: if (last_bit && !accept) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // A reload at the last-bit edge takes priority over the shift, which is
  // what gives back-to-back words zero gap cycles.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      shreg_q <= '0;
      cnt_q   <= '0;
    end else if (accept) begin
      shreg_q <= load_data;
      cnt_q   <= CNT_LAST;
    end else if (state_q == ST_SHIFT) begin
      shreg_q <= shreg_next;
      if (cnt_q != '0) begin
        cnt_q <= cnt_q - CNT_ONE;
      end
    end
  end

  assign busy      = (state_q == ST_SHIFT);
  assign ser_valid = busy;
  assign done      = last_bit;
  assign ser_out   = busy && (MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0]);

endmodule
